// File: rtl/systolic_feed_ctrl.sv
// Sequencer for the 9-lane input skew formatter: issues operand buffer reads,
// flushes the skew registers with zeros and tracks per-lane output validity.
//
// state | meaning
// IDLE  | waiting for start
// FEED  | one buffer read per cycle, len cycles
// FLUSH | buffer latency plus skew drain, LANES cycles
// DONE  | one-cycle completion pulse
module systolic_feed_ctrl #(
    parameter int LANES  = 9,
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              abort,
    output logic              buf_rd_en,
    output logic [ADDR_W-1:0] buf_rd_addr,
    output logic              feed_valid,
    output logic [LANES-1:0]  col_valid,
    output logic              acc_clear,
    output logic              busy,
    output logic              done,
    output logic [15:0]       tile_cnt
);

    localparam int CNT_W = (LEN_W > $clog2(LANES)) ? LEN_W : $clog2(LANES);

    typedef enum logic [1:0] {IDLE, FEED, FLUSH, DONE} state_t;

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [ADDR_W-1:0] addr, addr_d;
    logic              abort_hit;
    logic              fv;
    logic [LANES-2:0]  dly;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        addr_d    = addr;
        acc_clear = 1'b0;
        buf_rd_en = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        abort_hit = abort && (state != IDLE);
        case (state)
            IDLE: begin
                busy = 1'b0;
                // abort outranks start even though it has nothing to cancel here
                if (start && !abort) begin
                    if (len != '0) begin
                        state_d   = FEED;
                        cnt_d     = CNT_W'(len - LEN_W'(1));
                        addr_d    = base_addr;
                        acc_clear = !reset;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            FEED: begin
                buf_rd_en = 1'b1;
                if (cnt == '0) begin
                    state_d = FLUSH;
                    cnt_d   = CNT_W'(LANES - 1);
                end else begin
                    cnt_d  = cnt - CNT_W'(1);
                    addr_d = addr + ADDR_W'(1);
                end
            end
            FLUSH: begin
                if (cnt == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort_hit) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            addr     <= '0;
            tile_cnt <= '0;
            fv       <= 1'b0;
            dly      <= '0;
        end else begin
            cnt  <= cnt_d;
            addr <= addr_d;
            if (done && !abort) begin
                tile_cnt <= tile_cnt + 16'd1;
            end
            // an abort wipes the whole skew valid pipeline at once
            if (abort_hit) begin
                fv  <= 1'b0;
                dly <= '0;
            end else begin
                fv  <= buf_rd_en;
                dly <= {dly[LANES-3:0], fv};
            end
        end
    end

    assign buf_rd_addr = buf_rd_en ? addr : '0;
    assign feed_valid  = fv;
    assign col_valid   = {dly, fv};

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Bench for systolic_feed_ctrl: directed test-plan scenarios then random
// commands, all compared against a cycle-window reference model.
module tb_systolic_feed_ctrl;

    localparam int LANES = 9;

    logic        clk;
    logic        reset;
    logic        start;
    logic [9:0]  len;
    logic [9:0]  base_addr;
    logic        abort;
    logic        buf_rd_en;
    logic [9:0]  buf_rd_addr;
    logic        feed_valid;
    logic [8:0]  col_valid;
    logic        acc_clear;
    logic        busy;
    logic        done;
    logic [15:0] tile_cnt;

    systolic_feed_ctrl #(.LANES(LANES), .ADDR_W(10), .LEN_W(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .len        (len),
        .base_addr  (base_addr),
        .abort      (abort),
        .buf_rd_en  (buf_rd_en),
        .buf_rd_addr(buf_rd_addr),
        .feed_valid (feed_valid),
        .col_valid  (col_valid),
        .acc_clear  (acc_clear),
        .busy       (busy),
        .done       (done),
        .tile_cnt   (tile_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // reference model: one tile described by start cycle, length, base, abort cycle
    bit          have;
    int          ts, tl, tb, ta;
    logic [15:0] m_tiles;
    int          cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step(input logic st, input logic [9:0] ln, input logic [9:0] ba, input logic ab);
        int k, dur, a;
        bit act;
        logic e_busy, e_rd, e_fv, e_done, e_acc;
        logic [9:0] e_addr;
        logic [8:0] e_col;
        @(posedge clk);
        #1;
        start = st; len = ln; base_addr = ba; abort = ab;
        k      = cyc - ts;
        act    = have && (cyc <= ta);
        dur    = (tl == 0) ? 1 : tl + LANES + 1;
        e_busy = act && k >= 1 && k <= dur;
        e_rd   = act && k >= 1 && k <= tl;
        a      = (tb + k - 1) & 1023;
        e_addr = e_rd ? 10'(a) : 10'd0;
        e_fv   = act && k >= 2 && k <= tl + 1;
        for (int i = 0; i < LANES; i++) begin
            e_col[i] = act && k >= 2 + i && k <= tl + 1 + i;
        end
        e_done = act && k == dur;
        e_acc  = !e_busy && st && !ab && ln != 10'd0;
        @(negedge clk);
        check("busy",       32'(busy),        32'(e_busy));
        check("buf_rd_en",  32'(buf_rd_en),   32'(e_rd));
        check("rd_addr",    32'(buf_rd_addr), 32'(e_addr));
        check("feed_valid", 32'(feed_valid),  32'(e_fv));
        check("col_valid",  32'(col_valid),   32'(e_col));
        check("done",       32'(done),        32'(e_done));
        check("acc_clear",  32'(acc_clear),   32'(e_acc));
        check("tile_cnt",   32'(tile_cnt),    32'(m_tiles));
        if (e_done && !ab) m_tiles = m_tiles + 16'd1;
        if (e_busy && ab) ta = cyc;
        if (!e_busy && st && !ab) begin
            have = 1'b1; ts = cyc; tl = int'(ln); tb = int'(ba); ta = 1 << 30;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 10'd0, 10'd0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  32'(busy),        32'd0);
        check({tag, "_rd"},    32'(buf_rd_en),   32'd0);
        check({tag, "_addr"},  32'(buf_rd_addr), 32'd0);
        check({tag, "_fv"},    32'(feed_valid),  32'd0);
        check({tag, "_col"},   32'(col_valid),   32'd0);
        check({tag, "_done"},  32'(done),        32'd0);
        check({tag, "_acc"},   32'(acc_clear),   32'd0);
        check({tag, "_tiles"}, 32'(tile_cnt),    32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; len = '0; base_addr = '0; abort = 1'b0;
        have = 1'b0; ts = 0; tl = 0; tb = 0; ta = 0; m_tiles = '0; cyc = 0;
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // basic tile
        step(1'b1, 10'd4, 10'h010, 1'b0);
        idle(15);
        check("basic_tiles", 32'(tile_cnt), 32'd1);

        // address wrap
        step(1'b1, 10'd3, 10'h3FE, 1'b0);
        idle(14);

        // zero length
        step(1'b1, 10'd0, 10'h123, 1'b0);
        idle(3);

        // start while busy, then start right after done
        step(1'b1, 10'd4, 10'h020, 1'b0);
        idle(2);
        step(1'b1, 10'd7, 10'h100, 1'b0);
        idle(11);
        step(1'b1, 10'd2, 10'h040, 1'b0);
        idle(15);

        // abort mid-feed, then a normal tile
        step(1'b1, 10'd6, 10'h050, 1'b0);
        idle(2);
        step(1'b0, 10'd0, 10'd0, 1'b1);
        idle(5);
        step(1'b1, 10'd3, 10'h060, 1'b0);
        idle(15);

        // asynchronous reset in flush
        step(1'b1, 10'd4, 10'h070, 1'b0);
        idle(6);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check_all_zero("midreset");
        have = 1'b0; m_tiles = '0;
        @(negedge clk);
        reset = 1'b0;
        cyc++;
        idle(20);

        for (int n = 0; n < 3000; n++) begin
            logic st, ab;
            logic [9:0] ln, ba;
            st = ($urandom_range(0, 5) == 0);
            ln = ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom_range(1, 24));
            ba = 10'($urandom_range(0, 1023));
            ab = !st && ($urandom_range(0, 39) == 0);
            step(st, ln, ba, ab);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
